servile_timer: RTL and testbench
================================

Name: servile_timer

Overview:
- Wishbone responder (target) that sits on the servile extension bus (`o_wb_ext_*` / `i_wb_ext_*`).
- Holds a 64-bit RISC-V style mtime counter with a programmable prescaler, plus a 64-bit mtimecmp register.
- Drives the CPU `i_timer_irq` input.
- The CPU side is the initiator; this block is the responding end of that bus and the source of the timer interrupt.

Parameters:
- reset_en, 1'b1, value of CTRL.en after reset.
- reset_div, 8'd0, value of CTRL.div after reset; mtime increments every div+1 clock cycles.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_wb_adr  input  32  byte address; only bits [4:2] decoded, other bits ignored
- i_wb_dat  input  32  write data
- i_wb_sel  input  4  byte enables for writes
- i_wb_we  input  1  1 = write, 0 = read
- i_wb_stb  input  1  request strobe (doubles as cyc)
- o_wb_rdt  output  32  read data
- o_wb_ack  output  1  transfer acknowledge
- o_timer_irq  output  1  timer interrupt to the CPU

Behaviour:
- Reset values (asynchronous):
  - o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL.en=reset_en, CTRL.div=reset_div, prescale count=0, snapshot=0.
- Register map (index = adr[4:2]):
  - 0: MTIME_LO, R/W.
  - 1: MTIME_HI, R/W.
  - 2: MTIMECMP_LO, R/W.
  - 3: MTIMECMP_HI, R/W.
  - 4: CTRL, R/W. bit0=en, bits[15:8]=div, other bits read 0.
  - 5: MTIME_HI_SNAP, RO.
  - 6, 7: read 0, writes ignored.
- Handshake:
  - stb sampled high while ack=0 → ack=1 on the next cycle (1-cycle latency).
  - ack is always a single-cycle pulse; the cycle after an ack, ack=0 even if stb is still high.
  - A stb held continuously is therefore acked every second cycle. The master must drop stb in the ack cycle.
- Read data: o_wb_rdt is registered alongside ack and equals the addressed register as sampled in the request cycle. It is 0 whenever ack=0.
- Writes:
  - Commit at the request edge (the edge that sets ack).
  - Per-byte per i_wb_sel; unselected bytes are unchanged.
  - Writes to RO or unmapped locations still ack.
- Snapshot: a read of MTIME_LO loads mtime[63:32] into the snapshot in the same cycle it samples mtime[31:0]. Software reads LO then SNAP for a coherent 64-bit value.
- Prescaler:
  - 8-bit count; only runs while en=1.
  - When count==div: count←0, tick=1. Otherwise count←count+1.
  - Writing CTRL clears count to 0.
  - div=0 gives a tick every cycle.
  - en=0 freezes both count and mtime.
- mtime increment:
  - On tick, mtime←mtime+1 as a full 64-bit add; LO→HI carry in the same cycle.
  - Wraps at 2^64-1 → 0.
- Write vs tick collision: a write to MTIME_LO or MTIME_HI in a tick cycle wins. Written bytes take the write data; unwritten bytes keep their pre-tick value. That increment is discarded.
- Interrupt:
  - o_timer_irq registered: o_timer_irq ← en & (mtime ≥ mtimecmp), unsigned 64-bit compare on current register values.
  - Asserts one cycle after the condition holds; level-sensitive.
  - Clears one cycle after mtimecmp is raised above mtime or en is cleared.
  - A 32-bit partial mtimecmp update may glitch the irq; software convention is HI=all-ones, then LO, then HI.
- Reset mid-transfer: ack, rdt and all state return to reset values immediately. A pending request is dropped, never acked. The master re-issues after reset.

Decomposition:
- Shared package servile_timer_pkg:
  - Register index constants (MTIME_LO=3'd0 … MTIME_HI_SNAP=3'd5).
  - CTRL field positions: EN_BIT=0, DIV_LSB=8, DIV_MSB=15.
  - MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module servile_timer_prescaler:
  - Inputs: i_clk, i_rst, i_en, i_div[7:0], i_clr.
  - Output: o_tick.
  - Holds the count.
- Top level holds the register file, bus FSM (IDLE/ACK as a single ack flop), snapshot and irq compare.

Test Plan:
- Post-reset, read index 2, 3, 4 → rdt=FFFFFFFF, FFFFFFFF, 0x00000001 (reset_en=1, reset_div=0). Ack exactly 1 cycle after stb. irq=0.
- Write CTRL=0x00000301 (div=3), wait 40 cycles, read MTIME_LO → value within 10±1. Consecutive ticks are exactly 4 cycles apart.
- Write MTIME_LO=FFFFFFFE, MTIME_HI=0 with div=0; after 2 ticks read LO then SNAP → LO=0, SNAP=1 (carry).
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, mtime=0, div=0 → irq rises the cycle after mtime reaches 20. Write MTIMECMP_LO=1000 → irq falls 1 cycle later.
- Byte write sel=4'b0010, dat=0x0000AB00 to MTIME_LO coinciding with a tick → byte1=0xAB, other bytes keep pre-tick values, no increment that cycle.
- stb held high for 6 cycles → ack pattern 0,1,0,1,0,1. Reads of unmapped index 7 → rdt=0 with ack. Async reset asserted during a pending request → ack never asserted, rdt=0.

Source files
------------

// File: rtl/servile_timer_pkg.sv
// Shared definitions for the servile mtime/mtimecmp timer.
// Latency: n/a (constants, types and a byte-merge helper only).
// Backpressure: n/a.
package servile_timer_pkg;

  // Register indices, decoded from adr[4:2]
  localparam logic [2:0] MTIME_LO      = 3'd0;
  localparam logic [2:0] MTIME_HI      = 3'd1;
  localparam logic [2:0] MTIMECMP_LO   = 3'd2;
  localparam logic [2:0] MTIMECMP_HI   = 3'd3;
  localparam logic [2:0] CTRL          = 3'd4;
  localparam logic [2:0] MTIME_HI_SNAP = 3'd5;

  // CTRL field positions
  localparam int EN_BIT  = 0;
  localparam int DIV_LSB = 8;
  localparam int DIV_MSB = 15;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bus handshake: the ACK state is the registered acknowledge itself
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  // Per-byte write merge: selected bytes take new data, others keep old
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servile_timer_prescaler.sv
// Prescaler that divides the clock by div+1 to produce the mtime tick.
// Latency: tick is combinational from the registered count (same cycle).
// Backpressure: none; en=0 freezes the count, clr forces it to zero.
// Ports: i_clk, i_rst (async, high), i_en, i_div[7:0], i_clr -> o_tick.
module servile_timer_prescaler
  import servile_timer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_div,
  input  logic       i_clr,
  output logic       o_tick
);

  logic [7:0] count_q;

  // Tick fires in the cycle the count has reached div
  assign o_tick = i_en && (count_q == i_div);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= 8'd0;
    end else if (i_clr) begin
      count_q <= 8'd0;
    end else if (i_en) begin
      if (count_q == i_div) count_q <= 8'd0;
      else                  count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/servile_timer.sv
// Wishbone-responding 64-bit mtime/mtimecmp timer driving the CPU timer irq.
// Latency: ack and read data one cycle after stb; irq one cycle after compare.
// Backpressure: ack is a one-cycle pulse, a held stb is acked every 2nd cycle.
// Ports: i_clk, i_rst (async, high); wishbone i_wb_adr/dat/sel/we/stb,
//        o_wb_rdt, o_wb_ack; o_timer_irq.
module servile_timer
  import servile_timer_pkg::*;
#(
  parameter logic       reset_en  = 1'b1,
  parameter logic [7:0] reset_div = 8'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  bus_state_t  state_q, state_d;
  logic        req;
  logic [2:0]  idx;
  logic        wr;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q;
  logic [31:0] snap_q;
  logic        en_q;
  logic [7:0]  div_q;
  logic        ctrl_wr;
  logic        tick;
  logic [31:0] rd_mux;
  logic [31:0] rdt_q;
  logic        irq_q;

  // Only adr[4:2] selects a register
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

  assign idx     = i_wb_adr[4:2];
  assign wr      = req && i_wb_we;
  assign ctrl_wr = wr && (idx == CTRL);

  // Bus FSM: a request is only taken while not already acking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= BUS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    req     = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (i_wb_stb) begin
          state_d = BUS_ACK;
          req     = 1'b1;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  assign o_wb_ack = (state_q == BUS_ACK);

  servile_timer_prescaler u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (en_q),
    .i_div  (div_q),
    .i_clr  (ctrl_wr),
    .o_tick (tick)
  );

  // A software write to either mtime half overrides the tick; both halves
  // then hold their pre-tick value except for the written bytes.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr && idx == MTIME_LO)
      mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], i_wb_dat, i_wb_sel)};
    if (wr && idx == MTIME_HI)
      mtime_d = {byte_merge(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
  end

  always_comb begin
    rd_mux = 32'd0;
    case (idx)
      MTIME_LO:      rd_mux = mtime_q[31:0];
      MTIME_HI:      rd_mux = mtime_q[63:32];
      MTIMECMP_LO:   rd_mux = mtimecmp_q[31:0];
      MTIMECMP_HI:   rd_mux = mtimecmp_q[63:32];
      CTRL: begin
        rd_mux[EN_BIT]          = en_q;
        rd_mux[DIV_MSB:DIV_LSB] = div_q;
      end
      MTIME_HI_SNAP: rd_mux = snap_q;
      default:       rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      snap_q     <= 32'd0;
      en_q       <= reset_en;
      div_q      <= reset_div;
      rdt_q      <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      rdt_q   <= req ? rd_mux : 32'd0;
      irq_q   <= en_q && (mtime_q >= mtimecmp_q);
      // Latch the upper half together with the lower-half read
      if (req && !i_wb_we && idx == MTIME_LO) snap_q <= mtime_q[63:32];
      if (wr && idx == MTIMECMP_LO)
        mtimecmp_q[31:0] <= byte_merge(mtimecmp_q[31:0], i_wb_dat, i_wb_sel);
      if (wr && idx == MTIMECMP_HI)
        mtimecmp_q[63:32] <= byte_merge(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
      if (ctrl_wr) begin
        if (i_wb_sel[0]) en_q  <= i_wb_dat[EN_BIT];
        if (i_wb_sel[1]) div_q <= i_wb_dat[DIV_MSB:DIV_LSB];
      end
    end
  end

  assign o_wb_rdt    = rdt_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_servile_timer.sv
module tb_servile_timer;
  import servile_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        we  = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  servile_timer #(.reset_en(1'b1), .reset_div(8'd0)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_adr    (adr),
    .i_wb_dat    (dat),
    .i_wb_sel    (sel),
    .i_wb_we     (we),
    .i_wb_stb    (stb),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_timer_irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus transfer; checks that ack comes exactly one cycle after stb.
  task automatic xfer(input logic w, input logic [2:0] i, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
    int  lat;
    bit  got;
    if (ack) begin
      @(posedge clk); #1;
    end
    adr = {27'h4000123, i, 2'b01};
    dat = d; sel = s; we = w; stb = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (ack) got = 1;
    end
    r = rdt;
    stb = 1'b0; we = 1'b0;
    check("ack_latency", lat, 1);
  endtask

  logic [31:0] r;
  int first;

  initial begin
    tbl[0]  = '{1'b0, 3'd2, 32'h0,        4'h0, 32'hFFFFFFFF};
    tbl[1]  = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hFFFFFFFF};
    tbl[2]  = '{1'b0, 3'd4, 32'h0,        4'h0, 32'h00000001};
    tbl[3]  = '{1'b0, 3'd5, 32'h0,        4'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'd6, 32'h0,        4'h0, 32'h0};
    tbl[5]  = '{1'b0, 3'd7, 32'h0,        4'h0, 32'h0};
    tbl[6]  = '{1'b1, 3'd2, 32'h12345678, 4'h3, 32'hFFFFFFFF};
    tbl[7]  = '{1'b0, 3'd2, 32'h0,        4'h0, 32'hFFFF5678};
    tbl[8]  = '{1'b1, 3'd3, 32'hAABBCCDD, 4'h8, 32'hFFFFFFFF};
    tbl[9]  = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hAAFFFFFF};
    tbl[10] = '{1'b1, 3'd6, 32'h12345678, 4'hF, 32'h0};
    tbl[11] = '{1'b0, 3'd6, 32'h0,        4'h0, 32'h0};
    tbl[12] = '{1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[13] = '{1'b0, 3'd5, 32'h0,        4'h0, 32'h0};
    tbl[14] = '{1'b1, 3'd4, 32'h0000FF00, 4'hE, 32'h00000001};
    tbl[15] = '{1'b0, 3'd4, 32'h0,        4'h0, 32'h0000FF01};
    tbl[16] = '{1'b1, 3'd4, 32'hFFFFFF00, 4'h1, 32'h0000FF01};
    tbl[17] = '{1'b0, 3'd4, 32'h0,        4'h0, 32'h0000FF00};
    tbl[18] = '{1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, 32'hFFFF5678};
    tbl[19] = '{1'b1, 3'd3, 32'hFFFFFFFF, 4'hF, 32'hAAFFFFFF};

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", ack, 0);
    check("rst_rdt", rdt, 0);
    check("rst_irq", irq, 0);

    // Register map / byte enables / reset values
    for (int k = 0; k < 20; k++) begin
      xfer(tbl[k].we, tbl[k].idx, tbl[k].dat, tbl[k].sel, r);
      check($sformatf("vec%0d_rdt", k), r, tbl[k].exp_rdt);
    end
    check("irq_after_table", irq, 0);

    // Prescaler div=3: ticks at CTRL-write edge + 4k
    xfer(1, CTRL, 32'h0, 4'hF, r);
    xfer(1, MTIME_LO, 32'h0, 4'hF, r);
    xfer(1, MTIME_HI, 32'h0, 4'hF, r);
    xfer(1, CTRL, 32'h301, 4'hF, r);
    repeat (43) @(posedge clk);
    #1;
    xfer(0, MTIME_LO, 32'h0, 4'h0, r); check("div3_t44", r, 10);
    xfer(0, MTIME_LO, 32'h0, 4'h0, r); check("div3_t46", r, 11);
    xfer(0, MTIME_LO, 32'h0, 4'h0, r); check("div3_t48", r, 11);
    xfer(0, MTIME_LO, 32'h0, 4'h0, r); check("div3_t50", r, 12);

    // LO->HI carry and snapshot
    xfer(1, CTRL, 32'h0, 4'hF, r);
    xfer(1, MTIME_LO, 32'hFFFFFFFE, 4'hF, r);
    xfer(1, MTIME_HI, 32'h0, 4'hF, r);
    xfer(1, CTRL, 32'h1, 4'hF, r);
    repeat (2) @(posedge clk);
    #1;
    xfer(0, MTIME_LO, 32'h0, 4'h0, r);      check("carry_lo", r, 0);
    xfer(0, MTIME_HI_SNAP, 32'h0, 4'h0, r); check("carry_snap", r, 1);
    xfer(0, MTIME_HI, 32'h0, 4'h0, r);      check("carry_hi", r, 1);

    // irq rise at mtime==cmp, fall after cmp raised
    xfer(1, CTRL, 32'h0, 4'hF, r);
    xfer(1, MTIMECMP_HI, 32'h0, 4'hF, r);
    xfer(1, MTIMECMP_LO, 32'd20, 4'hF, r);
    xfer(1, MTIME_LO, 32'h0, 4'hF, r);
    xfer(1, MTIME_HI, 32'h0, 4'hF, r);
    check("irq_disabled", irq, 0);
    xfer(1, CTRL, 32'h1, 4'hF, r);
    first = -1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (irq && first < 0) first = j;
    end
    check("irq_rise_cycle", first, 21);
    xfer(1, MTIMECMP_LO, 32'd1000, 4'hF, r);
    check("irq_hold_write_cycle", irq, 1);
    @(posedge clk); #1;
    check("irq_fall", irq, 0);

    // Byte write to MTIME_LO colliding with a tick
    xfer(1, CTRL, 32'h0, 4'hF, r);
    xfer(1, MTIME_LO, 32'h11223344, 4'hF, r);
    xfer(1, MTIME_HI, 32'h0, 4'hF, r);
    xfer(1, CTRL, 32'h1, 4'hF, r);
    xfer(1, MTIME_LO, 32'h0000AB00, 4'b0010, r); check("collide_pre", r, 32'h11223345);
    xfer(0, MTIME_LO, 32'h0, 4'h0, r);           check("collide_post", r, 32'h1122AB46);

    // stb held high for 6 cycles on MTIMECMP_LO (=1000)
    @(posedge clk); #1;
    adr = {27'h0, MTIMECMP_LO, 2'b00}; we = 1'b0; sel = 4'h0; stb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("held_ack%0d", k), ack, k % 2);
      check($sformatf("held_rdt%0d", k), rdt, (k % 2) ? 32'd1000 : 32'd0);
    end
    stb = 1'b0;
    @(posedge clk); #1;

    // Reset while a request is pending: never acked
    adr = {27'h0, MTIMECMP_LO, 2'b00}; stb = 1'b1;
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_pend_ack", ack, 0);
      check("rst_pend_rdt", rdt, 0);
    end
    stb = 1'b0;
    rst = 1'b0;
    check("rst_pend_irq", irq, 0);

    // Reset asserted while ack is high: ack and rdt drop at once
    @(posedge clk); #1;
    stb = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", ack, 1);
    check("pre_rst_rdt", rdt, 32'hFFFFFFFF);
    rst = 1'b1;
    #1;
    check("async_rst_ack", ack, 0);
    check("async_rst_rdt", rdt, 0);
    stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, CTRL, 32'h0, 4'h0, r);        check("post_rst_ctrl", r, 1);
    xfer(0, MTIMECMP_LO, 32'h0, 4'h0, r); check("post_rst_cmp", r, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
